drive_pwm: RTL and testbench
============================

# drive_pwm

Motor-drive output stage directly downstream of the robot's top-level FSM. It consumes the FSM's `drive_state` command and the microphone-derived `speed` level, and produces two PWM/direction pairs for the left and right H-bridges. It adds three behaviours: glitch-free period-aligned duty updates, ramped acceleration and deceleration, and a mandatory brake interval before any motor reverses.

## Interface
Parameters:
- `PWM_PERIOD`, 2500: PWM period in clk_50 cycles (20 kHz). Must be ≤ 2^DUTY_W − 1.
- `DUTY_W`, 12: width of the duty and PWM counters.
- `RAMP_STEP`, 25: duty counts moved per ramp tick.
- `RAMP_STEP_CYCLES`, 50000: cycles between ramp ticks (1 ms).
- `BRAKE_CYCLES`, 5000000: brake hold length (100 ms).

Ports:
- `clk_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `drive_state`  in  3  command: 0 STOP, 1 FWD, 2 REV, 3 LEFT, 4 RIGHT; codes 5–7 are treated as STOP.
- `speed`  in  2  speed level 0–3.
- `mot_l_pwm`  out  1  left motor PWM.
- `mot_l_dir`  out  1  left motor direction (0 forward, 1 reverse).
- `mot_r_pwm`  out  1  right motor PWM.
- `mot_r_dir`  out  1  right motor direction.
- `busy`  out  1  high while in BRAKE or while either current duty differs from its target.

## Operation
- Inputs are registered into `drv_q`/`spd_q` every cycle. All decisions use the registered copies.
- Target duty per motor is set by speed: 0 → 0; 1 → PWM_PERIOD*2/5; 2 → PWM_PERIOD*7/10; 3 → PWM_PERIOD. All are integer division, evaluated at elaboration.
- Requested directions per motor: FWD is L0/R0. REV is L1/R1. LEFT pivots as L1/R0. RIGHT pivots as L0/R1. STOP sets target 0 with requested direction equal to current direction.
- States:
  - RUN (reset state):
    - A free-running `ramp_cnt` counts 0..RAMP_STEP_CYCLES−1.
    - On wrap, each motor's `duty_cur` moves toward its target by min(RAMP_STEP, |target − duty_cur|).
    - For a motor with `duty_cur` = 0, a requested direction change is loaded into its dir register immediately, with no brake.
    - If either motor has `duty_cur` ≠ 0 and a requested direction that differs from its dir register, go to BRAKE.
  - BRAKE:
    - Both `duty_cur` are forced to 0 and both PWM outputs are forced low immediately.
    - `ramp_cnt` is cleared and `brake_cnt` counts from 0.
    - When `brake_cnt` = BRAKE_CYCLES−1: load both dir registers from the current requests, clear `brake_cnt`, go to RUN. Ramping then restarts from 0.
    - Input changes during BRAKE do not extend the brake. The requests present on the exit cycle win.
- PWM generation:
  - `pwm_cnt` runs free over 0..PWM_PERIOD−1 and is cleared only by reset.
  - `duty_app` latches `duty_cur` only when `pwm_cnt` = 0.
  - Output is `pwm <= (pwm_cnt < duty_app)`, gated low in BRAKE.
  - Duty = PWM_PERIOD gives a constant high; duty = 0 gives a constant low.
- Reset (synchronous, any state, including mid-brake or mid-ramp) clears all counters, duties, dir registers, state, and outputs.

## Timing
- Reset values: `mot_l_pwm`, `mot_r_pwm`, `mot_l_dir`, `mot_r_dir`, `busy` are all 0; state is RUN.
- Input change at edge N is registered at N. The state or target reacts at N+1. Registered outputs reflect it at N+1.
- Brake entry: PWM outputs are low from edge N+1 and stay low for exactly BRAKE_CYCLES cycles. Directions change on the BRAKE→RUN edge.
- Ramp: from 0 to target T takes ceil(T/RAMP_STEP) ticks. Visible PWM lags by up to PWM_PERIOD cycles because of the period-aligned latch.
- Simultaneous ramp tick and brake entry: brake wins.
- Target change mid-ramp: the next tick moves toward the new target without overshoot.

## Configuration
- `DRIVE_PWM_RAMP_EN` defined: ramping behaves as described above.
- `DRIVE_PWM_RAMP_EN` undefined:
  - `duty_cur` equals the target on the cycle after the inputs are registered.
  - `ramp_cnt` is removed.
  - `busy` reflects BRAKE only.
  - The brake and the period-aligned latch are unchanged.

## Test plan
All scenarios use bench parameters PWM_PERIOD=100, RAMP_STEP=10, RAMP_STEP_CYCLES=4, BRAKE_CYCLES=20, with ramping enabled unless stated.
1. Reset held 3 cycles with random inputs -> all outputs 0; after release with STOP/speed 0, outputs stay 0 and `busy` stays 0.
2. FWD, speed 2 from rest -> `duty_cur` goes 10, 20, … 70, one step every 4 cycles; `busy` falls after the 7th tick; settled `mot_l_pwm`/`mot_r_pwm` are high 70 of every 100 cycles; both dirs 0.
3. Settled FWD speed 3, then REV -> both PWM low from the cycle after the registered change, for exactly 20 cycles; dirs become 1 on the exit edge; duty then ramps 0 → 100 in 10 ticks.
4. Settled FWD speed 3, then speed 1 -> no brake; duty steps 100 → 40 in 6 ticks; dirs unchanged.
5. drive_state=6 while running FWD speed 2 -> treated as STOP: ramps to 0, dirs held at 0. Then RIGHT -> left dir 0, right dir 1 applied with no brake, since both duties are 0.
6. Reset asserted on the 10th BRAKE cycle -> next edge: state RUN, all counters and outputs 0. Repeat scenario 2 with `DRIVE_PWM_RAMP_EN` undefined -> duty 70 is latched at the first `pwm_cnt`=0 after the input change.

Source files
------------

// File: rtl/drive_pwm.sv
// Dual H-bridge PWM stage: period-aligned duty updates, mandatory brake before reversal.
// Optional feature macro DRIVE_PWM_RAMP_EN: when defined, duty changes are ramped; otherwise they step at once.
module drive_pwm #(
  parameter int PWM_PERIOD       = 2500,
  parameter int DUTY_W           = 12,
  parameter int RAMP_STEP        = 25,
  parameter int RAMP_STEP_CYCLES = 50000,
  parameter int BRAKE_CYCLES     = 5000000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [2:0] drive_state,
  input  logic [1:0] speed,
  output logic       mot_l_pwm,
  output logic       mot_l_dir,
  output logic       mot_r_pwm,
  output logic       mot_r_dir,
  output logic       busy
);

  localparam int BRK_W = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
  localparam logic [BRK_W-1:0]  BRAKE_LAST  = BRK_W'(BRAKE_CYCLES - 1);
  localparam logic [DUTY_W-1:0] PERIOD_LAST = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_S1     = DUTY_W'(PWM_PERIOD * 2 / 5);
  localparam logic [DUTY_W-1:0] DUTY_S2     = DUTY_W'(PWM_PERIOD * 7 / 10);
  localparam logic [DUTY_W-1:0] DUTY_S3     = DUTY_W'(PWM_PERIOD);

  typedef enum logic {
    RUN   = 1'b0,
    BRAKE = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]              drv_q;
  logic [1:0]              spd_q;
  logic [DUTY_W-1:0]       tgt_spd;
  logic                    moving;
  logic [1:0]              cmd_dir;
  logic [1:0]              req_dir;
  logic [1:0]              brake_req;
  logic [1:0]              pwm_out;
  logic [1:0]              dir_out;
  logic [1:0][DUTY_W-1:0]  duty_cur;
  logic [1:0][DUTY_W-1:0]  duty_app;
  logic [DUTY_W-1:0]       pwm_cnt_reg;
  logic [BRK_W-1:0]        brake_cnt_reg, brake_cnt_next;
  logic                    need_brake;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      drv_q <= '0;
      spd_q <= '0;
    end else begin
      drv_q <= drive_state;
      spd_q <= speed;
    end
  end

  // Command decode; index 0 is the left motor, index 1 the right.
  always_comb begin
    tgt_spd = '0;
    moving  = 1'b1;
    cmd_dir = 2'b00;
    case (spd_q)
      2'd1:    tgt_spd = DUTY_S1;
      2'd2:    tgt_spd = DUTY_S2;
      2'd3:    tgt_spd = DUTY_S3;
      default: tgt_spd = '0;
    endcase
    case (drv_q)
      3'd1:    cmd_dir = 2'b00;
      3'd2:    cmd_dir = 2'b11;
      3'd3:    cmd_dir = 2'b01;
      3'd4:    cmd_dir = 2'b10;
      default: moving  = 1'b0;
    endcase
  end

`ifdef DRIVE_PWM_RAMP_EN
  localparam int RAMP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);

  logic [RAMP_W-1:0] ramp_cnt_reg;
  logic              ramp_tick;
  logic [1:0]        off_target;

  always_ff @(posedge clk_50) begin
    if (reset || state_reg == BRAKE || state_next == BRAKE) begin
      ramp_cnt_reg <= '0;
    end else if (ramp_cnt_reg == RAMP_LAST) begin
      ramp_cnt_reg <= '0;
    end else begin
      ramp_cnt_reg <= ramp_cnt_reg + 1'b1;
    end
  end

  assign ramp_tick = (ramp_cnt_reg == RAMP_LAST);
  assign busy      = (state_reg == BRAKE) || (|off_target);
`else
  assign busy = (state_reg == BRAKE);
`endif

  assign need_brake = |brake_req;

  always_comb begin
    state_next     = state_reg;
    brake_cnt_next = brake_cnt_reg;
    case (state_reg)
      RUN: begin
        if (need_brake) begin
          state_next     = BRAKE;
          brake_cnt_next = '0;
        end
      end
      BRAKE: begin
        if (brake_cnt_reg == BRAKE_LAST) begin
          state_next     = RUN;
          brake_cnt_next = '0;
        end else begin
          brake_cnt_next = brake_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next     = RUN;
        brake_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg     <= RUN;
      brake_cnt_reg <= '0;
      pwm_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      brake_cnt_reg <= brake_cnt_next;
      pwm_cnt_reg   <= (pwm_cnt_reg == PERIOD_LAST) ? '0 : pwm_cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_motor
      logic [DUTY_W-1:0] target;
      logic [DUTY_W-1:0] duty_cur_reg, duty_cur_next;
      logic [DUTY_W-1:0] duty_app_reg;
      logic              dir_reg, dir_next;
      logic              pwm_reg;

      // STOP keeps the present direction so it never triggers a brake.
      assign target         = moving ? tgt_spd : '0;
      assign req_dir[gi]    = moving ? cmd_dir[gi] : dir_reg;
      assign brake_req[gi]  = (duty_cur_reg != '0) && (req_dir[gi] != dir_reg);
      assign duty_cur[gi]   = duty_cur_reg;
      assign duty_app[gi]   = duty_app_reg;
      assign pwm_out[gi]    = pwm_reg;
      assign dir_out[gi]    = dir_reg;
`ifdef DRIVE_PWM_RAMP_EN
      assign off_target[gi] = (duty_cur_reg != target);
`endif

      always_comb begin
        duty_cur_next = duty_cur_reg;
        dir_next      = dir_reg;
        if (state_next == BRAKE) begin
          duty_cur_next = '0;
        end else if (state_reg == BRAKE) begin
          duty_cur_next = '0;
          dir_next      = req_dir[gi];
        end else begin
          if (duty_cur_reg == '0) begin
            dir_next = req_dir[gi];
          end
`ifdef DRIVE_PWM_RAMP_EN
          if (ramp_tick) begin
            if (target > duty_cur_reg) begin
              duty_cur_next = (target - duty_cur_reg > STEP) ? duty_cur_reg + STEP : target;
            end else if (target < duty_cur_reg) begin
              duty_cur_next = (duty_cur_reg - target > STEP) ? duty_cur_reg - STEP : target;
            end
          end
`else
          duty_cur_next = target;
`endif
        end
      end

      // The applied duty only changes at a period boundary, so no pulse is ever truncated.
      always_ff @(posedge clk_50) begin
        if (reset) begin
          duty_cur_reg <= '0;
          duty_app_reg <= '0;
          dir_reg      <= 1'b0;
          pwm_reg      <= 1'b0;
        end else begin
          duty_cur_reg <= duty_cur_next;
          dir_reg      <= dir_next;
          if (pwm_cnt_reg == '0) begin
            duty_app_reg <= duty_cur_reg;
          end
          pwm_reg <= (state_next == RUN) && (pwm_cnt_reg < duty_app[gi]);
        end
      end
    end
  endgenerate

  assign mot_l_pwm = pwm_out[0];
  assign mot_r_pwm = pwm_out[1];
  assign mot_l_dir = dir_out[0];
  assign mot_r_dir = dir_out[1];

endmodule

// File: tb/tb_drive_pwm.sv
// Directed bench for drive_pwm with a scoreboard queue of expected values.
// Works with DRIVE_PWM_RAMP_EN either defined or undefined.
module tb_drive_pwm;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] drive_state = 3'd0;
  logic [1:0] speed = 2'd0;
  logic       mot_l_pwm, mot_l_dir, mot_r_pwm, mot_r_dir, busy;

  always #5 clk_50 = ~clk_50;

  drive_pwm #(
    .PWM_PERIOD(100),
    .DUTY_W(12),
    .RAMP_STEP(10),
    .RAMP_STEP_CYCLES(4),
    .BRAKE_CYCLES(20)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .drive_state(drive_state),
    .speed(speed),
    .mot_l_pwm(mot_l_pwm),
    .mot_l_dir(mot_l_dir),
    .mot_r_pwm(mot_r_pwm),
    .mot_r_dir(mot_r_dir),
    .busy(busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard: observed %0d with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  // Follows both duties from from_v to to_v; with ramping each step is 10 counts, 4 cycles apart.
  task automatic ramp_check(input string tag, input int from_v, input int to_v);
    int exp_v = from_v;
    int prev = from_v;
    int cnt = 0;
    int last = -1;
    int t;
`ifdef DRIVE_PWM_RAMP_EN
    while (exp_v != to_v) begin
      if (to_v > exp_v) exp_v = (to_v - exp_v > 10) ? exp_v + 10 : to_v;
      else              exp_v = (exp_v - to_v > 10) ? exp_v - 10 : to_v;
      push({tag, " duty_l"}, exp_v);
      t = 0;
      while (int'(dut.duty_cur[0]) == prev && t < 50) begin
        cyc(1);
        cnt++;
        t++;
      end
      pop_check(32'(dut.duty_cur[0]));
      push({tag, " duty_r"}, exp_v);
      pop_check(32'(dut.duty_cur[1]));
      push({tag, " busy"}, 32'(exp_v != to_v));
      pop_check(32'(busy));
      if (last >= 0) begin
        push({tag, " tick interval"}, 4);
        pop_check(cnt - last);
      end
      if (t >= 50) break;
      last = cnt;
      prev = int'(dut.duty_cur[0]);
    end
`else
    t = 0;
    while (int'(dut.duty_cur[0]) != to_v && t < 3) begin
      cyc(1);
      t++;
    end
    push({tag, " duty_l"}, to_v);
    pop_check(32'(dut.duty_cur[0]));
    push({tag, " duty_r"}, to_v);
    pop_check(32'(dut.duty_cur[1]));
    push({tag, " busy"}, 0);
    pop_check(32'(busy));
`endif
  endtask

  task automatic count_high(input string tag, input int exp_hi);
    int hl = 0;
    int hr = 0;
    cyc(150);
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      hl += int'(mot_l_pwm);
      hr += int'(mot_r_pwm);
    end
    push({tag, " left highs"}, exp_hi);
    pop_check(hl);
    push({tag, " right highs"}, exp_hi);
    pop_check(hr);
  endtask

  initial begin
    int t;

    // 1: reset with random inputs, then idle release
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      drive_state = 3'($urandom_range(7));
      speed = 2'($urandom_range(3));
      cyc(1);
      push("reset outputs", 0);
      pop_check(32'({mot_l_pwm, mot_l_dir, mot_r_pwm, mot_r_dir, busy}));
    end
    push("reset state", 0);
    pop_check(32'(dut.state_reg));
    reset = 1'b0;
    drive_state = 3'd0;
    speed = 2'd0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      push("idle outputs", 0);
      pop_check(32'({mot_l_pwm, mot_l_dir, mot_r_pwm, mot_r_dir, busy}));
    end

    // 2: FWD speed 2 from rest
    drive_state = 3'd1;
    speed = 2'd2;
`ifdef DRIVE_PWM_RAMP_EN
    ramp_check("s2 ramp", 0, 70);
`else
    cyc(1);
    push("s2 duty before react", 0);
    pop_check(32'(dut.duty_cur[0]));
    cyc(1);
    push("s2 duty after react", 70);
    pop_check(32'(dut.duty_cur[0]));
    t = 0;
    while (int'(dut.duty_app[0]) != 70 && t < 150) begin
      cyc(1);
      t++;
    end
    push("s2 applied duty", 70);
    pop_check(32'(dut.duty_app[0]));
    push("s2 latch phase", 1);
    pop_check(32'(dut.pwm_cnt_reg));
`endif
    count_high("s2 settled", 70);
    push("s2 dirs", 0);
    pop_check(32'({mot_l_dir, mot_r_dir}));

    // 3: settle at full speed, then reverse through the brake
    speed = 2'd3;
    ramp_check("s3 up", 70, 100);
    cyc(200);
    t = 0;
    while (int'(dut.pwm_cnt_reg) != 5 && t < 150) begin
      cyc(1);
      t++;
    end
    drive_state = 3'd2;
    cyc(1);
    push("s3 pwm before brake", 3);
    pop_check(32'({mot_l_pwm, mot_r_pwm}));
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      push("s3 brake pwm", 0);
      pop_check(32'({mot_l_pwm, mot_r_pwm}));
      push("s3 brake dirs", 0);
      pop_check(32'({mot_l_dir, mot_r_dir}));
    end
    cyc(1);
    push("s3 exit dirs", 3);
    pop_check(32'({mot_l_dir, mot_r_dir}));
    push("s3 exit pwm", 3);
    pop_check(32'({mot_l_pwm, mot_r_pwm}));
    push("s3 exit state", 0);
    pop_check(32'(dut.state_reg));
    ramp_check("s3 rev ramp", 0, 100);

    // 4: slow down without reversing
    speed = 2'd1;
    ramp_check("s4 down", 100, 40);
    push("s4 dirs", 3);
    pop_check(32'({mot_l_dir, mot_r_dir}));
    push("s4 state", 0);
    pop_check(32'(dut.state_reg));

    // 5: FWD speed 2, then code 6 acts as STOP, then RIGHT pivot from rest
    drive_state = 3'd1;
    speed = 2'd2;
    t = 0;
    while ((busy || int'(dut.duty_cur[0]) != 70) && t < 300) begin
      cyc(1);
      t++;
    end
    push("s5 fwd duty", 70);
    pop_check(32'(dut.duty_cur[0]));
    push("s5 fwd dirs", 0);
    pop_check(32'({mot_l_dir, mot_r_dir}));
    drive_state = 3'd6;
    ramp_check("s5 stop", 70, 0);
    push("s5 stop dirs", 0);
    pop_check(32'({mot_l_dir, mot_r_dir}));
    drive_state = 3'd4;
    cyc(2);
    push("s5 right dirs", 1);
    pop_check(32'({mot_l_dir, mot_r_dir}));
    push("s5 right no brake", 0);
    pop_check(32'(dut.state_reg));
    ramp_check("s5 right", 0, 70);

    // 6: reset in the middle of a brake
    drive_state = 3'd3;
    cyc(11);
    push("s6 in brake", 1);
    pop_check(32'(dut.state_reg));
    reset = 1'b1;
    drive_state = 3'($urandom_range(7));
    cyc(1);
    push("s6 state", 0);
    pop_check(32'(dut.state_reg));
    push("s6 outputs", 0);
    pop_check(32'({mot_l_pwm, mot_l_dir, mot_r_pwm, mot_r_dir, busy}));
    push("s6 duties", 0);
    pop_check(32'({dut.duty_cur[0], dut.duty_cur[1]}));
    push("s6 brake_cnt", 0);
    pop_check(32'(dut.brake_cnt_reg));
    push("s6 pwm_cnt", 0);
    pop_check(32'(dut.pwm_cnt_reg));
`ifdef DRIVE_PWM_RAMP_EN
    push("s6 ramp_cnt", 0);
    pop_check(32'(dut.ramp_cnt_reg));
`endif
    reset = 1'b0;
    drive_state = 3'd0;
    speed = 2'd0;
    cyc(3);
    push("s6 idle outputs", 0);
    pop_check(32'({mot_l_pwm, mot_l_dir, mot_r_pwm, mot_r_dir, busy}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
